// File: rtl/cordic_vec_iter.sv
// Iterative CORDIC vectoring engine: (x, y) -> atan2 angle in Q15.16 degrees and magnitude.
// Define CORDIC_GAIN_COMP_EN to scale the magnitude by 1/K in an extra GAIN cycle.
module cordic_vec_iter #(
    parameter int N_ITER = 16,
    parameter int W_INT  = 34
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      x_in,
    input  logic [31:0]      y_in,
    output logic             busy,
    output logic             done,
    output logic [31:0]      angle,
    output logic [W_INT-1:0] modulus
);

    localparam logic signed [31:0] Z_180 = 32'sd11796480;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ROT,
        S_GAIN,
        S_DONE
    } state_t;

    state_t                  state;
    logic [4:0]              i;
    logic signed [W_INT-1:0] x;
    logic signed [W_INT-1:0] y;
    logic signed [W_INT-1:0] xs;
    logic signed [W_INT-1:0] ys;
    logic signed [31:0]      z;
    logic signed [31:0]      atan_i;

    function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    return 32'sd2949120;
            5'd1:    return 32'sd1740967;
            5'd2:    return 32'sd919879;
            5'd3:    return 32'sd466945;
            5'd4:    return 32'sd234379;
            5'd5:    return 32'sd117304;
            5'd6:    return 32'sd58666;
            5'd7:    return 32'sd29335;
            5'd8:    return 32'sd14668;
            5'd9:    return 32'sd7334;
            5'd10:   return 32'sd3667;
            5'd11:   return 32'sd1833;
            5'd12:   return 32'sd917;
            5'd13:   return 32'sd458;
            5'd14:   return 32'sd229;
            5'd15:   return 32'sd115;
            5'd16:   return 32'sd57;
            5'd17:   return 32'sd29;
            5'd18:   return 32'sd14;
            5'd19:   return 32'sd7;
            5'd20:   return 32'sd4;
            5'd21:   return 32'sd2;
            5'd22:   return 32'sd1;
            default: return 32'sd0;
        endcase
    endfunction

    always_comb begin
        xs     = x >>> i;
        ys     = y >>> i;
        atan_i = atan_lut(i);
    end

`ifdef CORDIC_GAIN_COMP_EN
    logic [W_INT+15:0] prod;
    always_comb prod = {16'd0, x} * (W_INT+16)'(39797);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            i       <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            angle   <= '0;
            modulus <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x     <= {{(W_INT-32){x_in[31]}}, x_in};
                        y     <= {{(W_INT-32){y_in[31]}}, y_in};
                        i     <= '0;
                        state <= S_PRE;
                    end
                end
                S_PRE: begin
                    // Left half-plane: rotate by 180 deg; z sign follows the original y.
                    if (x[W_INT-1]) begin
                        x <= -x;
                        y <= -y;
                        z <= y[W_INT-1] ? -Z_180 : Z_180;
                    end else begin
                        z <= '0;
                    end
                    busy  <= 1'b1;
                    i     <= '0;
                    state <= S_ROT;
                end
                S_ROT: begin
                    if (!y[W_INT-1]) begin
                        x <= x + ys;
                        y <= y - xs;
                        z <= z + atan_i;
                    end else begin
                        x <= x - ys;
                        y <= y + xs;
                        z <= z - atan_i;
                    end
                    if (i == 5'(N_ITER - 1)) begin
                        i <= '0;
`ifdef CORDIC_GAIN_COMP_EN
                        state <= S_GAIN;
`else
                        state <= S_DONE;
`endif
                    end else begin
                        i <= i + 5'd1;
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_GAIN: begin
                    x     <= prod[W_INT+15:16];
                    state <= S_DONE;
                end
`endif
                S_DONE: begin
                    angle   <= z;
                    modulus <= $unsigned(x);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
